main_slave_driver: RTL and testbench

Bus-initiator block for the slave RAM port of a Bambu-generated `main` accelerator. A host-side command/response handshake is converted into slave-port reads and writes on channel 0, plus start/done run sequencing with a cycle count. It sits between a host sequencer or self-checking harness and the accelerator. It is used to preload inputs such as the 128-byte `MEM_var_26078_26084` array, launch `main`, and read back results, without the bench driving the slave port directly.

---
 rtl/main_slave_driver_pkg.sv | 23 ++
 rtl/main_slave_driver_cycle_counter.sv | 38 +++
 rtl/main_slave_driver.sv | 192 +++++++++++++++++++
 tb/tb_main_slave_driver.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/main_slave_driver_pkg.sv
// Shared definitions for the main_slave_driver slice: command op-codes,
// controller state encoding and default widths.
package main_slave_driver_pkg;

  localparam int DEF_ADDR_W         = 9;
  localparam int DEF_DATA_W         = 64;
  localparam int DEF_SIZE_W         = 7;
  localparam int DEF_CNT_W          = 32;
  localparam int DEF_TIMEOUT_CYCLES = 1024;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_RUN   = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RUN,
    RESP
  } state_t;

endpackage

// File: rtl/main_slave_driver_cycle_counter.sv
// slave_drv_cycle_counter: saturating up-counter with synchronous load.
// Used both for the run cycle count and for the wait timeout.
//   clock, reset : clock, asynchronous active-high reset
//   load         : load load_val (has priority over en)
//   en           : increment by one, holding at all-ones
//   load_val     : value loaded on load
//   tc_val       : terminal-count compare value
//   count        : current count
//   tc           : count == tc_val
//   sat          : count is all-ones
module slave_drv_cycle_counter #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  input  logic [W-1:0] tc_val,
  output logic [W-1:0] count,
  output logic         tc,
  output logic         sat
);

  assign sat = &count;
  assign tc  = (count == tc_val);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && !sat) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/main_slave_driver.sv
// main_slave_driver: turns a host command/response handshake into channel-0
// slave RAM accesses of the Bambu `main` accelerator, and sequences runs
// (start pulse, wait for done, report cycle count).
//   clock, reset        : clock, asynchronous active-high reset
//   cmd_*               : command handshake (op 00 read, 01 write, 10 run, 11 reserved)
//   rsp_*               : response handshake (data, error flag)
//   S_* / Sout_*        : slave port of `main`; channel 1 slices tied to 0
//   start_port/done_port: run control of `main`
// Optional build macro SLAVE_DRV_TIMEOUT_EN: abort ACCESS/RUN waits after
// TIMEOUT_CYCLES cycles with an error response. Without it waits are unbounded.
module main_slave_driver
  import main_slave_driver_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int SIZE_W         = DEF_SIZE_W,
  parameter int CNT_W          = DEF_CNT_W,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [SIZE_W-1:0]   cmd_size,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_data,
  output logic                rsp_err,
  output logic [1:0]          S_oe_ram,
  output logic [1:0]          S_we_ram,
  output logic [2*ADDR_W-1:0] S_addr_ram,
  output logic [2*DATA_W-1:0] S_Wdata_ram,
  output logic [2*SIZE_W-1:0] S_data_ram_size,
  input  logic [2*DATA_W-1:0] Sout_Rdata_ram,
  input  logic [1:0]          Sout_DataRdy,
  output logic                start_port,
  input  logic                done_port
);

  state_t              state_q, state_d;
  logic                live_q;
  logic                run_first_q;
  logic                accept;
  logic                timeout;
  logic [1:0]          op_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [SIZE_W-1:0]   size_q;
  logic [DATA_W-1:0]   rsp_data_q;
  logic                rsp_err_q;
  logic [CNT_W-1:0]    run_cnt;
  logic                run_tc_unused;
  logic                run_sat_unused;
  logic                unused_in;

  // Keep only the low min(sz, DATA_W) bits; oversize values select the full word.
  function automatic logic [DATA_W-1:0] size_mask(input logic [SIZE_W-1:0] sz);
    logic [DATA_W-1:0] m;
    m = '0;
    for (int i = 0; i < DATA_W; i++) begin
      if (i < int'(sz)) m[i] = 1'b1;
    end
    return m;
  endfunction

  function automatic logic [DATA_W-1:0] count_to_data(input logic [CNT_W-1:0] c);
    return DATA_W'(c);
  endfunction

  assign unused_in = ^{Sout_Rdata_ram[2*DATA_W-1:DATA_W], Sout_DataRdy[1]};

  // live_q holds cmd_ready low until the first clock after reset release.
  assign accept = cmd_valid && live_q && (state_q == IDLE);

  slave_drv_cycle_counter #(.W(CNT_W)) u_run_cnt (
    .clock    (clock),
    .reset    (reset),
    .load     (accept && (cmd_op == OP_RUN)),
    .en       (state_q == RUN),
    .load_val (CNT_W'(1)),
    .tc_val   ('0),
    .count    (run_cnt),
    .tc       (run_tc_unused),
    .sat      (run_sat_unused)
  );

`ifdef SLAVE_DRV_TIMEOUT_EN
  logic [CNT_W-1:0] wait_cnt_unused;
  logic             wait_sat_unused;

  // Counts 1 in the first waiting cycle, so tc fires after TIMEOUT_CYCLES cycles.
  slave_drv_cycle_counter #(.W(CNT_W)) u_wait_cnt (
    .clock    (clock),
    .reset    (reset),
    .load     (accept),
    .en       ((state_q == ACCESS) || (state_q == RUN)),
    .load_val (CNT_W'(1)),
    .tc_val   (CNT_W'(TIMEOUT_CYCLES)),
    .count    (wait_cnt_unused),
    .tc       (timeout),
    .sat      (wait_sat_unused)
  );
`else
  localparam int TIMEOUT_UNUSED = TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  // State register and control flags
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      live_q      <= 1'b0;
      run_first_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      live_q      <= 1'b1;
      run_first_q <= accept && (cmd_op == OP_RUN);
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          case (cmd_op)
            OP_READ, OP_WRITE: state_d = ACCESS;
            OP_RUN:            state_d = RUN;
            default:           state_d = RESP;
          endcase
        end
      end
      ACCESS:  if (Sout_DataRdy[0] || timeout) state_d = RESP;
      RUN:     if (done_port || timeout)       state_d = RESP;
      RESP:    if (rsp_ready)                  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Command and response payload; outputs are gated by state, so no reset needed.
  always_ff @(posedge clock) begin
    if (accept) begin
      op_q    <= cmd_op;
      addr_q  <= cmd_addr;
      wdata_q <= cmd_wdata;
      size_q  <= cmd_size;
    end
    if (accept && (cmd_op == OP_RSVD)) begin
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b1;
    end else if ((state_q == ACCESS) && Sout_DataRdy[0]) begin
      rsp_data_q <= (op_q == OP_READ) ? (Sout_Rdata_ram[DATA_W-1:0] & size_mask(size_q)) : '0;
      rsp_err_q  <= 1'b0;
    end else if ((state_q == RUN) && done_port) begin
      rsp_data_q <= count_to_data(run_cnt);
      rsp_err_q  <= 1'b0;
    end else if (((state_q == ACCESS) || (state_q == RUN)) && timeout) begin
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b1;
    end
  end

  // Output decode; an asynchronous reset to IDLE drops strobes and start at once.
  always_comb begin
    cmd_ready       = live_q && (state_q == IDLE);
    rsp_valid       = (state_q == RESP);
    rsp_data        = '0;
    rsp_err         = 1'b0;
    S_oe_ram        = '0;
    S_we_ram        = '0;
    S_addr_ram      = '0;
    S_Wdata_ram     = '0;
    S_data_ram_size = '0;
    start_port      = (state_q == RUN) && run_first_q;
    if (state_q == RESP) begin
      rsp_data = rsp_data_q;
      rsp_err  = rsp_err_q;
    end
    if (state_q == ACCESS) begin
      S_oe_ram[0]                    = (op_q == OP_READ);
      S_we_ram[0]                    = (op_q == OP_WRITE);
      S_addr_ram[ADDR_W-1:0]         = addr_q;
      S_Wdata_ram[DATA_W-1:0]        = wdata_q;
      S_data_ram_size[SIZE_W-1:0]    = size_q;
    end
  end

endmodule

// File: tb/tb_main_slave_driver.sv
// Self-checking bench for main_slave_driver. The bench acts as the slave RAM
// (a word array keyed by address) and as the `main` run controller, and
// predicts every response from the command-level behaviour.
module tb_main_slave_driver;
  import main_slave_driver_pkg::*;

  localparam int AW = 9;
  localparam int DW = 64;
  localparam int SW = 7;
  localparam int CW = 32;
`ifdef SLAVE_DRV_TIMEOUT_EN
  localparam int TB_TO = 16;
`else
  localparam int TB_TO = 1024;
`endif
  localparam int RUN_MAX = (TB_TO > 41) ? 40 : TB_TO - 1;

  logic            clock, reset;
  logic            cmd_valid, cmd_ready;
  logic [1:0]      cmd_op;
  logic [AW-1:0]   cmd_addr;
  logic [DW-1:0]   cmd_wdata;
  logic [SW-1:0]   cmd_size;
  logic            rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0]   rsp_data;
  logic [1:0]      S_oe_ram, S_we_ram, Sout_DataRdy;
  logic [2*AW-1:0] S_addr_ram;
  logic [2*DW-1:0] S_Wdata_ram, Sout_Rdata_ram;
  logic [2*SW-1:0] S_data_ram_size;
  logic            start_port, done_port;

  main_slave_driver #(
    .ADDR_W(AW), .DATA_W(DW), .SIZE_W(SW), .CNT_W(CW), .TIMEOUT_CYCLES(TB_TO)
  ) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_size(cmd_size),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .S_oe_ram(S_oe_ram), .S_we_ram(S_we_ram), .S_addr_ram(S_addr_ram),
    .S_Wdata_ram(S_Wdata_ram), .S_data_ram_size(S_data_ram_size),
    .Sout_Rdata_ram(Sout_Rdata_ram), .Sout_DataRdy(Sout_DataRdy),
    .start_port(start_port), .done_port(done_port)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_chk = 0;
  int n_err = 0;
  logic [63:0] mem [512];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_mask(input int sz);
    if (sz >= 64) return '1;
    return (64'd1 << sz) - 64'd1;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, {cmd_ready, rsp_valid, rsp_err, start_port, S_oe_ram, S_we_ram}, '0);
    chk({tag, "_rdata"}, rsp_data, '0);
    chk({tag, "_bus"}, {S_addr_ram, S_data_ram_size}, '0);
    chk({tag, "_wdata"}, S_Wdata_ram, '0);
  endtask

  // Entered at the negedge where the response must be visible.
  task automatic finish_resp(input string tag, input logic [63:0] ed, input logic ee, input int hold);
    for (int h = 0; h <= hold; h++) begin
      chk({tag, "_vld"}, rsp_valid, 1'b1);
      chk({tag, "_data"}, rsp_data, ed);
      chk({tag, "_err"}, rsp_err, ee);
      chk({tag, "_quiet"}, {S_oe_ram, S_we_ram, start_port, cmd_ready}, '0);
      if (h == hold) rsp_ready = 1'b1;
      @(negedge clock);
    end
    rsp_ready = 1'b0;
    chk({tag, "_ready_after"}, cmd_ready, 1'b1);
    chk({tag, "_vld_after"}, rsp_valid, 1'b0);
  endtask

  task automatic do_access(input logic [1:0] op, input logic [AW-1:0] addr, input logic [63:0] wd,
                           input logic [SW-1:0] sz, input int lat, input logic [63:0] junk, input int hold);
    logic [63:0] m, expd;
    m = ref_mask(int'(sz));
    chk("acc_ready", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_wdata = wd; cmd_size = sz;
    @(negedge clock);
    cmd_valid = 1'b0; cmd_addr = AW'($urandom); cmd_wdata = {$urandom, $urandom}; cmd_size = SW'($urandom);
    for (int k = 1; k <= lat; k++) begin
      chk("acc_oe", S_oe_ram, (op == OP_READ) ? 2'b01 : 2'b00);
      chk("acc_we", S_we_ram, (op == OP_WRITE) ? 2'b01 : 2'b00);
      chk("acc_addr", S_addr_ram, {9'd0, addr});
      chk("acc_size", S_data_ram_size, {7'd0, sz});
      if (op == OP_WRITE) chk("acc_wdata", S_Wdata_ram, {64'd0, wd});
      chk("acc_busy", {cmd_ready, rsp_valid, start_port}, '0);
      Sout_DataRdy = {1'($urandom), (k == lat)};
      if (k == lat) Sout_Rdata_ram = {$urandom, $urandom, (mem[addr] & m) | (junk & ~m)};
      else          Sout_Rdata_ram = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clock);
    end
    Sout_DataRdy = 2'b00;
    Sout_Rdata_ram = {$urandom, $urandom, $urandom, $urandom};
    if (op == OP_WRITE) begin
      mem[addr] = wd & m;
      expd = '0;
    end else begin
      expd = mem[addr] & m;
    end
    finish_resp((op == OP_WRITE) ? "wr" : "rd", expd, 1'b0, hold);
  endtask

  task automatic do_run(input int d, input int hold);
    chk("run_ready", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_op = OP_RUN;
    @(negedge clock);
    cmd_valid = 1'b0; cmd_op = 2'($urandom);
    for (int k = 1; k <= d + 1; k++) begin
      chk("run_start", start_port, k == 1);
      chk("run_quiet", {S_oe_ram, S_we_ram, rsp_valid, cmd_ready}, '0);
      Sout_DataRdy = 2'($urandom);
      if (k == d + 1) done_port = 1'b1;
      @(negedge clock);
    end
    done_port = 1'b0;
    Sout_DataRdy = 2'b00;
    finish_resp("run", 64'(d + 1), 1'b0, hold);
  endtask

  task automatic do_rsvd(input int hold);
    chk("rsvd_ready", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_op = OP_RSVD; cmd_addr = AW'($urandom); cmd_wdata = {$urandom, $urandom};
    @(negedge clock);
    cmd_valid = 1'b0; cmd_op = OP_READ;
    finish_resp("rsvd", 64'd0, 1'b1, hold);
  endtask

  function automatic logic [SW-1:0] pick_size();
    int s;
    s = $urandom_range(0, 8);
    if (s == 8) return SW'($urandom_range(0, 127));
    return SW'(8 << (s % 4));
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, expected finish before 1 ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_wdata = '0; cmd_size = '0;
    rsp_ready = 1'b0; Sout_Rdata_ram = '0; Sout_DataRdy = '0; done_port = 1'b0;
    foreach (mem[i]) mem[i] = {$urandom, $urandom};

    #12;
    chk_all_zero("rst");
    @(negedge clock);
    reset = 1'b0;
    chk("rst_release_ready", cmd_ready, 1'b0);
    @(negedge clock);
    chk("ready_after_rst", cmd_ready, 1'b1);
    chk("no_rsp_after_rst", rsp_valid, 1'b0);

    // DataRdy while idle must not produce anything.
    Sout_DataRdy = 2'b11;
    repeat (3) @(negedge clock);
    chk("idle_rdy_ignored", {cmd_ready, rsp_valid, S_oe_ram, S_we_ram}, 6'b100000);
    Sout_DataRdy = 2'b00;

    do_access(OP_WRITE, 9'h010, 64'h2A, 7'd32, 1, 64'd0, 0);
    do_access(OP_READ, 9'h010, 64'd0, 7'd8, 2, 64'hFFFF_FFFF_FFFF_FF00, 1);
`ifndef SLAVE_DRV_TIMEOUT_EN
    do_run(37, 0);
`endif
    do_run(0, 1);
    do_rsvd(5);
    do_access(OP_READ, 9'h010, 64'd0, 7'd100, 1, {$urandom, $urandom}, 0);
    do_access(OP_READ, 9'h018, 64'd0, 7'd0, 1, {$urandom, $urandom}, 0);
    do_access(OP_WRITE, 9'h020, 64'hDEAD_BEEF_0123_4567, 7'd16, 3, 64'd0, 2);
    do_access(OP_READ, 9'h020, 64'd0, 7'd64, 1, {$urandom, $urandom}, 0);

    for (int t = 0; t < 60; t++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: do_access(OP_WRITE, AW'($urandom_range(0, 7) * 8), {$urandom, $urandom},
                              pick_size(), $urandom_range(1, 5), 64'd0, $urandom_range(0, 3));
        4, 5, 6, 7: do_access(OP_READ, AW'($urandom_range(0, 7) * 8), {$urandom, $urandom},
                              pick_size(), $urandom_range(1, 5), {$urandom, $urandom}, $urandom_range(0, 3));
        8:          do_run($urandom_range(0, RUN_MAX), $urandom_range(0, 3));
        default:    do_rsvd($urandom_range(0, 3));
      endcase
    end

    // Reset in the middle of an access.
    cmd_valid = 1'b1; cmd_op = OP_READ; cmd_addr = 9'h030; cmd_size = 7'd64;
    @(negedge clock);
    cmd_valid = 1'b0;
    chk("rst_acc_oe_before", S_oe_ram, 2'b01);
    #2 reset = 1'b1;
    #1 chk_all_zero("rst_acc");
    @(negedge clock);
    reset = 1'b0;
    Sout_DataRdy = 2'b01;
    @(negedge clock);
    Sout_DataRdy = 2'b00;
    chk("rst_acc_ready", cmd_ready, 1'b1);
    chk("rst_acc_no_rsp", rsp_valid, 1'b0);
    @(negedge clock);
    chk("rst_acc_still_no_rsp", {rsp_valid, S_oe_ram}, '0);

    // Reset during the start cycle of a run.
    cmd_valid = 1'b1; cmd_op = OP_RUN;
    @(negedge clock);
    cmd_valid = 1'b0;
    chk("rst_run_start_before", start_port, 1'b1);
    #2 reset = 1'b1;
    #1 chk_all_zero("rst_run");
    @(negedge clock);
    reset = 1'b0;
    done_port = 1'b1;
    @(negedge clock);
    done_port = 1'b0;
    chk("rst_run_ready", cmd_ready, 1'b1);
    chk("rst_run_no_rsp", rsp_valid, 1'b0);
    do_run(3, 0);

`ifdef SLAVE_DRV_TIMEOUT_EN
    cmd_valid = 1'b1; cmd_op = OP_READ; cmd_addr = 9'h040; cmd_size = 7'd32;
    @(negedge clock);
    cmd_valid = 1'b0;
    for (int k = 1; k <= TB_TO; k++) begin
      chk("to_oe_held", S_oe_ram, 2'b01);
      @(negedge clock);
    end
    chk("to_oe_drop", S_oe_ram, 2'b00);
    finish_resp("to", 64'd0, 1'b1, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
